rw_mem_slave: RTL and testbench



---
 rtl/rw_mem_pkg.sv | 16 +
 rtl/rw_mem_array.sv | 32 +++
 rtl/rw_mem_slave.sv | 133 +++++++++++++
 tb/tb_rw_mem_slave.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rw_mem_pkg.sv
// Shared definitions for the rw_mem_slave storage target: FSM state encoding and default sizes.
package rw_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10
    } state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 4;
    localparam int DEPTH_DEF       = 12;
    localparam int WAIT_CYCLES_DEF = 1;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/rw_mem_array.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module rw_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 12
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: every word is reset, so this maps to flops rather than a RAM macro;
    // never-written words must read back as zero.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rw_mem_slave.sv
// Wait-stated read/write storage target with one-cycle completion and error pulses.
// Optional access counter output enabled by defining RW_MEM_ACCESS_CNT_EN.
module rw_mem_slave
    import rw_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              wack,
    output logic              busy,
`ifdef RW_MEM_ACCESS_CNT_EN
    output logic [15:0]       access_cnt,
`endif
    output logic              err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_L  = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t                state, next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  cap_wr;
    logic [ADDR_W-1:0]     cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    logic [DATA_W-1:0]     mem_rd_data;

    logic              capture, access_done, addr_ok, mem_we;
    logic              busy_d, wack_d, rvalid_d, err_d;
    logic [DATA_W-1:0] rdata_d;

    assign capture     = (state == IDLE) && (wr_en ^ rd_en);
    assign access_done = (state == ACCESS);
    assign addr_ok     = ({1'b0, cap_addr} < DEPTH_L);
    assign mem_we      = access_done && cap_wr && addr_ok;

    rw_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset_b (reset_b),
        .we      (mem_we),
        .wr_addr (cap_addr),
        .wr_data (cap_wdata),
        .rd_addr (cap_addr),
        .rd_data (mem_rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            state <= next_state;
            if (capture) begin
                wait_cnt  <= WAIT_L;
                cap_wr    <= wr_en;
                cap_addr  <= addr;
                cap_wdata <= wdata;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // NOTE: defaults first in every combinational block so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (capture) next_state = (WAIT_L == '0) ? ACCESS : WAIT;
            WAIT:    if (wait_cnt == WAIT_CNT_W'(1)) next_state = ACCESS;
            ACCESS:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; any request while not IDLE is a drop.
    always_comb begin
        busy_d   = (next_state != IDLE);
        wack_d   = access_done && cap_wr;
        rvalid_d = access_done && !cap_wr;
        err_d    = ((state == IDLE) && wr_en && rd_en)
                 || ((state != IDLE) && (wr_en || rd_en))
                 || (access_done && !addr_ok);
        rdata_d  = rdata;
        if (access_done && !cap_wr) begin
            rdata_d = addr_ok ? mem_rd_data : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            wack   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            rdata  <= rdata_d;
            rvalid <= rvalid_d;
            wack   <= wack_d;
            busy   <= busy_d;
            err    <= err_d;
        end
    end

`ifdef RW_MEM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            access_cnt <= '0;
        end else if (access_done && (access_cnt != 16'hFFFF)) begin
            access_cnt <= access_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rw_mem_slave.sv
// Scoreboard bench for rw_mem_slave: expected completions queued at request time, checked at negedge.
module tb_rw_mem_slave;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;
    localparam int WAIT_C = 1;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              rvalid, wack, busy, err;
`ifdef RW_MEM_ACCESS_CNT_EN
    logic [15:0]       access_cnt;
`endif

    rw_mem_slave #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_C)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .wack       (wack),
        .busy       (busy),
`ifdef RW_MEM_ACCESS_CNT_EN
        .access_cnt (access_cnt),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        bit              rd;
        logic [DATA_W-1:0] data;
        bit              err;
    } exp_t;

    exp_t              sb_q[$];
    bit                exp_err[int];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] last_rdata = '0;
    int                cyc = 0;
    int                cap_edge = -1;
    int                done_edge = -1;
    int                acnt = 0;
    bit                mon_en = 1'b0;
    int                vectors = 0;
    int                miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Drives one request so it is sampled on the next edge; model decides its fate.
    task automatic req(input logic w, input logic r, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int   m;
        exp_t e;
        m = cyc + 1;
        wr_en = w; rd_en = r; addr = a; wdata = d;
        if (w || r) begin
            if ((w && r) || (m <= done_edge)) begin
                exp_err[m] = 1'b1;
            end else begin
                cap_edge  = m;
                done_edge = m + 1 + WAIT_C;
                e.cyc  = done_edge;
                e.rd   = r;
                e.err  = (a >= DEPTH);
                e.data = (r && a < DEPTH) ? ref_mem[a] : '0;
                if (w && a < DEPTH) ref_mem[a] = d;
                sb_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_rdata = '0;
        cap_edge   = -1;
        done_edge  = -1;
        acnt       = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic ew, er, ee, eb;
            exp_t e;
            ew = 1'b0; er = 1'b0;
            ee = exp_err.exists(cyc);
            eb = (cyc >= cap_edge) && (cyc < done_edge);
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e  = sb_q.pop_front();
                ew = !e.rd;
                er = e.rd;
                ee = ee | e.err;
                acnt++;
                if (e.rd) last_rdata = e.data;
            end
            check("wack_rvalid_err_busy", {28'd0, wack, rvalid, err, busy}, {28'd0, ew, er, ee, eb});
            check("rdata", {24'd0, rdata}, {24'd0, last_rdata});
`ifdef RW_MEM_ACCESS_CNT_EN
            check("access_cnt", {16'd0, access_cnt}, acnt);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        check("reset_rdata", {24'd0, rdata}, 32'd0);
        check("reset_flags", {28'd0, wack, rvalid, err, busy}, 32'd0);
`ifdef RW_MEM_ACCESS_CNT_EN
        check("reset_access_cnt", {16'd0, access_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        reset_b = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // Basic write then read-back, and an untouched address.
        req(1, 0, 4'd3, 8'hA5); idle(4);
        req(0, 1, 4'd3, 8'h00); idle(4);
        req(0, 1, 4'd7, 8'h00); idle(4);

        // Both enables high: error only, memory untouched.
        req(1, 1, 4'd4, 8'h5A); idle(3);
        req(0, 1, 4'd4, 8'h00); idle(4);

        // Request one cycle into a write is dropped; request during ACCESS is dropped.
        req(1, 0, 4'd2, 8'h11); req(0, 1, 4'd5, 8'h00); idle(4);
        req(1, 0, 4'd6, 8'h66); idle(1); req(0, 1, 4'd6, 8'h00); idle(4);
        req(0, 1, 4'd2, 8'h00); idle(4);

        // Out-of-range write and read, then back-to-back reads of every word
        // issued in the completion cycle of the previous one.
        req(1, 0, 4'd13, 8'hFF); idle(4);
        req(0, 1, 4'd13, 8'h00); idle(4);
        for (int i = 0; i < DEPTH; i++) begin
            req(0, 1, ADDR_W'(i), 8'h00); idle(2);
        end
        idle(2);

        // Random traffic, including overlaps and collisions.
        for (int i = 0; i < 24; i++) begin
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            idle($urandom_range(0, 3));
        end
        idle(5);

        // Reset during the wait state of a write aborts it.
        req(1, 0, 4'd1, 8'h3C);
        reset_b = 1'b0;
        model_reset();
        idle(2);
        reset_b = 1'b1;
        idle(1);
        req(0, 1, 4'd1, 8'h00); idle(4);
        req(0, 1, 4'd3, 8'h00); idle(4);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
